// File: rtl/axi_pkg.sv
// Shared types, response codes and burst address arithmetic for the AXI write slave.
// Width defaults may be overridden on the tool command line.
`ifndef ID_W_WIDTH
`define ID_W_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BRESP_WIDTH
`define BRESP_WIDTH 2
`endif

package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;

  // Entries carry the widest supported fields; the top zero-extends into them.
  localparam int ID_MAX   = 16;
  localparam int ADDR_MAX = 64;

  typedef struct packed {
    logic [ID_MAX-1:0]   id;
    logic [ADDR_MAX-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
  } aw_entry_t;

  function automatic logic [ADDR_MAX-1:0] next_addr(
    input logic [ADDR_MAX-1:0] addr,
    input logic [7:0]          len,
    input logic [2:0]          size,
    input logic [1:0]          burst
  );
    logic [ADDR_MAX-1:0] incr;
    logic [ADDR_MAX-1:0] sum;
    logic [ADDR_MAX-1:0] wmask;
    logic [ADDR_MAX-1:0] result;
    incr  = ADDR_MAX'(1) << size;
    sum   = (addr & ~(incr - ADDR_MAX'(1))) + incr;
    // Wrap window is (len+1) transfers wide; keep the upper bits, let the low bits roll over.
    wmask = ((ADDR_MAX'(len) + ADDR_MAX'(1)) << size) - ADDR_MAX'(1);
    case (burst)
      2'b00:   result = addr;
      2'b01:   result = sum;
      2'b10:   result = (addr & ~wmask) | (sum & wmask);
      default: result = addr;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/axi_aw_fifo.sv
// Synchronous FIFO with first-word-fall-through read data, used as the
// outstanding write-address queue.
module axi_aw_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == CNT_W'(0));
  assign count     = count_q;
  assign rd_data   = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/axi_wr_slave_ctrl.sv
// AXI write-path slave: queues write addresses, expands each burst into per-beat
// memory writes and returns one B response per burst.
module axi_wr_slave_ctrl
  import axi_pkg::*;
#(
  parameter int ID_W_WIDTH  = `ID_W_WIDTH,
  parameter int ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int BRESP_WIDTH = `BRESP_WIDTH,
  parameter int AW_DEPTH    = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_W_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awlock,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_W_WIDTH-1:0]   bid,
  output logic [BRESP_WIDTH-1:0]  bresp,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);
  localparam int CNT_W    = $clog2(AW_DEPTH + 1);
  localparam int ENT_W    = $bits(aw_entry_t);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [ID_W_WIDTH-1:0]  bid_q, bid_d;
  logic [BRESP_WIDTH-1:0] bresp_q, bresp_d;
  logic [7:0]             beat_q, beat_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]      mem_wstrb_q, mem_wstrb_d;

  aw_entry_t              in_entry_s;
  aw_entry_t              head_s;
  logic [ENT_W-1:0]       head_bits_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CNT_W-1:0]       fifo_count_s;
  logic [CNT_W-1:0]       next_count_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   w_hs_s;
  logic                   last_beat_s;
  logic                   wlast_err_s;
  logic                   cfg_err_s;
  logic [ADDR_WIDTH-1:0]  beat_addr_s;
  logic [ADDR_MAX-1:0]    na_s;
  logic                   unused_s;

  assign push_s      = awvalid && awready_q;
  assign pop_s       = bvalid_q && bready;
  assign head_s      = aw_entry_t'(head_bits_s);
  assign w_hs_s      = wvalid && wready_q;
  assign last_beat_s = (beat_q == head_s.len);
  assign wlast_err_s = w_hs_s && (wlast != last_beat_s);
  // The head entry stays put until its B handshake, so beat 0 reads its address directly.
  assign beat_addr_s = (beat_q == 8'd0) ? head_s.addr[ADDR_WIDTH-1:0] : cur_addr_q;
  assign na_s        = next_addr(ADDR_MAX'(beat_addr_s), head_s.len, head_s.size, head_s.burst);
  assign unused_s    = ^{head_s.id[ID_MAX-1:ID_W_WIDTH], head_s.addr[ADDR_MAX-1:ADDR_WIDTH],
                         head_s.lock, na_s[ADDR_MAX-1:ADDR_WIDTH], fifo_full_s};

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  always_comb begin
    in_entry_s       = '0;
    in_entry_s.id    = ID_MAX'(awid);
    in_entry_s.addr  = ADDR_MAX'(awaddr);
    in_entry_s.len   = awlen;
    in_entry_s.size  = awsize;
    in_entry_s.burst = awburst;
    in_entry_s.lock  = awlock;
  end

  axi_aw_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (in_entry_s),
    .rd_data (head_bits_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  always_comb begin
    cfg_err_s = 1'b0;
    if (head_s.size > 3'(MAX_SIZE)) begin
      cfg_err_s = 1'b1;
    end else if (head_s.burst == 2'b11) begin
      cfg_err_s = 1'b1;
    end else if ((head_s.burst == WRAP) &&
                 !(head_s.len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
      cfg_err_s = 1'b1;
    end else begin
      cfg_err_s = 1'b0;
    end
  end

  always_comb begin
    next_count_s = fifo_count_s;
    if (push_s && !pop_s) begin
      next_count_s = fifo_count_s + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      next_count_s = fifo_count_s - CNT_W'(1);
    end else begin
      next_count_s = fifo_count_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    awready_d   = (next_count_s < CNT_W'(AW_DEPTH));
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    beat_d      = beat_q;
    err_d       = err_q;
    cur_addr_d  = cur_addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      S_IDLE: begin
        wready_d = 1'b0;
        // A push into an empty queue is visible at the head on the very next cycle.
        if (!fifo_empty_s || push_s) begin
          state_d  = S_DATA;
          wready_d = 1'b1;
          beat_d   = 8'd0;
          err_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_hs_s) begin
          mem_we_d    = !cfg_err_s;
          mem_addr_d  = beat_addr_s;
          mem_wdata_d = wdata;
          mem_wstrb_d = wstrb;
          cur_addr_d  = na_s[ADDR_WIDTH-1:0];
          beat_d      = beat_q + 8'd1;
          err_d       = err_q || wlast_err_s;
          if (last_beat_s) begin
            state_d  = S_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = head_s.id[ID_W_WIDTH-1:0];
            bresp_d  = (cfg_err_s || err_q || wlast_err_s) ? SLVERR : OKAY;
          end else begin
            wready_d = 1'b1;
          end
        end else begin
          wready_d = 1'b1;
        end
      end
      S_RESP: begin
        if (pop_s) begin
          bvalid_d = 1'b0;
          if ((fifo_count_s > CNT_W'(1)) || push_s) begin
            state_d  = S_DATA;
            wready_d = 1'b1;
            beat_d   = 8'd0;
            err_d    = 1'b0;
          end else begin
            state_d  = S_IDLE;
            wready_d = 1'b0;
          end
        end else begin
          bvalid_d = 1'b1;
          wready_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        wready_d = 1'b0;
        bvalid_d = 1'b0;
      end
    endcase
  end

  // Controller state and all registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      beat_q      <= 8'd0;
      err_q       <= 1'b0;
      cur_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      cur_addr_q  <= cur_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

endmodule

// File: doc/axi_wr_slave_ctrl.md
# axi_wr_slave_ctrl

Parametrised AXI write-path slave controller for the AXI UVC testbench. It accepts write addresses into an outstanding-request FIFO, consumes W beats per burst, and generates per-beat write addresses (FIXED/INCR/WRAP) onto a simple memory write port. It returns one B response per burst and flags protocol errors with SLVERR. It sits behind the AXI interface as the DUT-side responder for write traffic.

## Interface
- ID_W_WIDTH, default `ID_W_WIDTH: AWID/BID width.
- ADDR_WIDTH, default `ADDR_WIDTH: address width.
- DATA_WIDTH, default `DATA_WIDTH: data width, power of two, ≥8.
- BRESP_WIDTH, default `BRESP_WIDTH: BRESP width, must be 2.
- AW_DEPTH, default 4: outstanding write-address entries, ≥1.
- aclk in 1: clock, all state on rising edge.
- aresetn in 1: asynchronous active-low reset.
- awvalid in 1 / awready out 1 / awid in ID_W_WIDTH / awaddr in ADDR_WIDTH / awlen in 8 / awsize in 3 / awburst in 2 / awlock in 1: write-address channel.
- wvalid in 1 / wready out 1 / wdata in DATA_WIDTH / wstrb in DATA_WIDTH/8 / wlast in 1: write-data channel.
- bvalid out 1 / bready in 1 / bid out ID_W_WIDTH / bresp out BRESP_WIDTH: write-response channel.
- mem_we out 1 / mem_addr out ADDR_WIDTH / mem_wdata out DATA_WIDTH / mem_wstrb out DATA_WIDTH/8: registered memory write port.

## Operation
- AW FIFO: pushed on awvalid&&awready; popped on the bvalid&&bready handshake. Each entry holds {id, addr, len, size, burst, lock}. Count width is $clog2(AW_DEPTH+1).
- awready is registered. Its next value is (next_count < AW_DEPTH). A simultaneous push and pop leaves the count unchanged. A push is never accepted while full.
- FSM states: IDLE, DATA, RESP.
  - IDLE: wready=0. When the FIFO is non-empty, go to DATA and load the head entry. Clear the beat counter (8 bit), the err flag, and cur_addr=awaddr.
  - DATA: wready=1. Each W handshake writes one beat. On beat == len, go to RESP.
  - RESP: wready=0, bvalid=1, bid=head id, bresp=OKAY(00) or SLVERR(10). On bready, pop. Go to DATA if another entry remains, else IDLE.
- Beat address:
  - FIXED: constant awaddr.
  - INCR: aligned(addr) + beat·2^size.
  - WRAP: boundary = awaddr aligned down to (len+1)·2^size; the address wraps to the boundary on reaching boundary+(len+1)·2^size.
  - Arithmetic is modulo 2^ADDR_WIDTH.
- Error (err flag, bresp=SLVERR), evaluated per burst:
  - awsize > log2(DATA_WIDTH/8): all beats have mem_we suppressed.
  - awburst == 2'b11: mem_we suppressed.
  - WRAP with len ∉ {1,3,7,15}: mem_we suppressed.
  - wlast=1 on a beat < len, or wlast=0 on beat == len: data is still written; the burst always ends after exactly len+1 beats.
- awlock=1 (exclusive) returns OKAY. Exclusive access is unsupported.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. The FIFO is emptied and the FSM is IDLE.
- awready rises on the first edge after aresetn deasserts.
- AW handshake at cycle N into an empty FIFO in IDLE: DATA is entered and wready=1 at N+1.
- W handshake at cycle M: mem_we/mem_addr/mem_wdata/mem_wstrb are valid for exactly cycle M+1.
- Last beat at M: bvalid=1 from M+1 until the bready handshake. bid and bresp are stable while bvalid=1.
- B handshake at cycle K with a pending entry: DATA at K+1. There is one idle W cycle between bursts.
- Back-to-back beats sustain 1 beat/cycle. bready=1 while waiting gives a burst cost of len+3 cycles.
- Reset asserted mid-burst: everything clears immediately. The partial burst gets no B response.

## Structure
- axi_pkg holds:
  - burst_t enum: FIXED=00, INCR=01, WRAP=10.
  - resp constants: OKAY=00, EXOKAY=01, SLVERR=10.
  - aw_entry_t packed struct.
  - address-calculation function next_addr(addr, len, size, burst).
- Sub-module axi_aw_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with push/pop, full, empty and count outputs. It is instantiated once for the AW queue.

## Test plan
- INCR write: awaddr=0x100, len=3, size=2, 32-bit data, bready=1 -> mem_addr 0x100/0x104/0x108/0x10C on consecutive cycles, bresp=00, bid=awid.
- WRAP write: awaddr=0x38, len=3, size=2 -> addresses 0x38, 0x3C, 0x30, 0x34, bresp=00.
- Outstanding: push 5 AWs with AW_DEPTH=4 and wvalid=0 -> awready=0 after the 4th acceptance. It returns to 1 the cycle after the first B handshake. B ids arrive in issue order.
- Error: awsize=3 with 32-bit data, len=1 -> two beats accepted, mem_we never asserts, bresp=10. Early wlast on beat 0 of len=2 -> three beats written, bresp=10.
- Backpressure: hold bready=0 for 5 cycles -> bvalid, bid and bresp stay stable, wready=0, and the next burst does not start until the handshake.
- Reset at beat 2 of len=7 -> all outputs reach reset values immediately. After release, a new len=0 burst completes with bresp=00.
